proc_mem_pipe: RTL

PROC_MEM_PIPE -- requirements
Module: proc_mem_pipe

---
 rtl/proc_pkg.sv | 20 ++
 rtl/proc_mem_pipe_if.sv | 34 +++
 rtl/proc_rf.sv | 36 +++
 rtl/proc_mem_pipe.sv | 139 +++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared opcode and FSM state types for the proc_mem_pipe slice.
// Width of the retire counter lives here so bench and RTL agree on it.
package proc_pkg;

  typedef enum logic [1:0] {
    OP_INC   = 2'd0,
    OP_STORE = 2'd1,
    OP_LOAD  = 2'd2,
    OP_ADD   = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam int RETIRE_W = 16;

endpackage

// File: rtl/proc_mem_pipe_if.sv
// Instruction and memory request/response bundle for proc_mem_pipe.
// master = instruction source plus memory model; slave = the processor.
interface proc_mem_pipe_if #(
  parameter int DW = 8,
  parameter int RW = 2
);
  logic          inst_valid;
  logic          inst_ready;
  logic [1:0]    op;
  logic [RW-1:0] operand1;
  logic [RW-1:0] operand2;

  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [DW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;

  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_data;

  modport master (
    output inst_valid, op, operand1, operand2,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data,
    input  inst_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport slave (
    input  inst_valid, op, operand1, operand2,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
    output inst_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

endinterface

// File: rtl/proc_rf.sv
// NREG x DW register file: two combinational read ports, one write port.
// Reads see the pre-edge value, so a same-cycle read/write of one entry returns old data.
module proc_rf
  import proc_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int RW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [RW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [RW-1:0] rb_addr,
  output logic [DW-1:0] rb_data,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  logic [DW-1:0] regs [NREG];

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/proc_mem_pipe.sv
// Tiny in-order processor: INC/ADD retire in one cycle, STORE/LOAD go through a REQ/WAIT memory FSM.
// inst_ready is low whenever a memory op is in flight; define PROC_ADD_OP_EN to make op 3 an ADD (else NOP).
module proc_mem_pipe
  import proc_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int RW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  proc_mem_pipe_if.slave      bus,
  output logic [RETIRE_W-1:0] retire_cnt
);

  state_t        state_q;
  state_t        state_d;
  op_t           op;
  logic          accept;
  logic          retire;

  logic          we_q;
  logic [DW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [RW-1:0] dst_q;

  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic          rf_we;
  logic [RW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  assign op             = op_t'(bus.op);
  assign bus.inst_ready = (state_q == IDLE);
  assign accept         = bus.inst_valid && (state_q == IDLE);

  assign bus.mem_req_valid = (state_q == REQ);
  assign bus.mem_req_we    = we_q;
  assign bus.mem_req_addr  = addr_q;
  assign bus.mem_req_wdata = wdata_q;

  proc_rf #(
    .DW   (DW),
    .NREG (NREG),
    .RW   (RW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (bus.operand1),
    .ra_data (ra_data),
    .rb_addr (bus.operand2),
    .rb_data (rb_data),
    .wr_en   (rf_we),
    .wr_addr (rf_wa),
    .wr_data (rf_wd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rf_we   = 1'b0;
    rf_wa   = bus.operand1;
    rf_wd   = '0;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.inst_valid) begin
          case (op)
            OP_INC: begin
              rf_we  = 1'b1;
              rf_wd  = rb_data + 1'b1;
              retire = 1'b1;
            end
            OP_STORE, OP_LOAD: begin
              state_d = REQ;
            end
            OP_ADD: begin
`ifdef PROC_ADD_OP_EN
              rf_we  = 1'b1;
              rf_wd  = ra_data + rb_data;
`endif
              retire = 1'b1;
            end
            default: ;
          endcase
        end
      end
      REQ: begin
        if (bus.mem_req_ready) begin
          state_d = we_q ? IDLE : WAIT;
          retire  = we_q;
        end
      end
      WAIT: begin
        // Response data lands in the destination captured at accept time.
        if (bus.mem_rsp_valid) begin
          state_d = IDLE;
          rf_we   = 1'b1;
          rf_wa   = dst_q;
          rf_wd   = bus.mem_rsp_data;
          retire  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dst_q      <= '0;
      retire_cnt <= '0;
    end else begin
      if (accept && op == OP_STORE) begin
        we_q    <= 1'b1;
        addr_q  <= ra_data;
        wdata_q <= rb_data;
      end
      if (accept && op == OP_LOAD) begin
        we_q   <= 1'b0;
        addr_q <= rb_data;
        dst_q  <= bus.operand1;
      end
      if (retire) begin
        retire_cnt <= retire_cnt + 1'b1;
      end
    end
  end

endmodule
